// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and helpers for the stream mux
// Purpose: arbitration mode encodings and the clog2 helper used to size
//          the channel index.
// Ports:   none (package)
package stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Width needed to hold an index in [0, v-1]; at least 1 for v<=2.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
// Purpose: pick exactly one requesting channel; honours a packet lock.
// Ports:
//   req      in   N     per-channel request
//   ptr      in   SELW  last granted channel (RR search starts at ptr+1)
//   mode     in   1     MODE_RR or MODE_FIXED
//   lock     in   1     grant restricted to lock_idx
//   lock_idx in   SELW  channel owning the lock
//   gnt      out  N     one-hot grant
//   gnt_idx  out  SELW  binary index of the grant
//   any_gnt  out  1     a grant was issued
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    input  logic            lock,
    input  logic [SELW-1:0] lock_idx,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any_gnt
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        if (lock) begin
            // Locked: only the owning channel may be granted, and only when it
            // actually has data; other channels wait even if valid.
            if (req[lock_idx]) begin
                gnt_idx = lock_idx;
                any_gnt = 1'b1;
            end
        end else if (mode == MODE_FIXED) begin
            // Descending scan: the last hit (lowest index) wins.
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_idx = SELW'(i);
                    any_gnt = 1'b1;
                end
            end
        end else begin
            // Scan offsets N..1 from ptr so the smallest offset (ptr+1) wins.
            for (int i = N; i >= 1; i--) begin
                idx = (int'(ptr) + i) % N;
                if (req[idx]) begin
                    gnt_idx = SELW'(idx);
                    any_gnt = 1'b1;
                end
            end
        end
        if (any_gnt) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered valid/ready stream multiplexer
// Purpose: arbitrates N input streams onto one registered output stream with
//          1-cycle latency and full throughput.
// Optional feature: STREAM_MUX_PKT_LOCK_EN adds I_LAST/Y_LAST and locks the
//          grant to one channel until the end of its packet.
// Ports:
//   CLK, RST (sync, active high), MODE (0=RR, 1=fixed priority)
//   I_VALID/I_DATA/I_READY  N input channels (channel k at I_DATA[k*W +: W])
//   I_LAST                  per-channel end of packet (lock build only)
//   Y_VALID/Y_DATA/Y_SEL/Y_READY  output stream and source channel index
//   Y_LAST                  registered end of packet (lock build only)
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = clog2(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            MODE,
    input  logic [N-1:0]    I_VALID,
    input  logic [N*W-1:0]  I_DATA,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [N-1:0]    I_LAST,
    output logic            Y_LAST,
`endif
    output logic [N-1:0]    I_READY,
    output logic            Y_VALID,
    output logic [W-1:0]    Y_DATA,
    output logic [SELW-1:0] Y_SEL,
    input  logic            Y_READY
);

    logic            load;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] gnt_idx;
    logic            any_gnt;
    logic [SELW-1:0] ptr;
    logic            lock;
    logic [SELW-1:0] lock_idx;

    // Output register can take a word when empty or being drained this cycle.
    assign load = !Y_VALID || Y_READY;

    // Suppress all handshakes during reset so no producer believes a word
    // was taken while the output register is being cleared.
    assign I_READY = (load && !RST) ? gnt : '0;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req      (I_VALID),
        .ptr      (ptr),
        .mode     (MODE),
        .lock     (lock),
        .lock_idx (lock_idx),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .any_gnt  (any_gnt)
    );

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic            lock_q;
    logic [SELW-1:0] lock_idx_q;

    assign lock     = lock_q;
    assign lock_idx = lock_idx_q;
`else
    assign lock     = 1'b0;
    assign lock_idx = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            Y_VALID <= 1'b0;
            Y_DATA  <= '0;
            Y_SEL   <= '0;
            ptr     <= SELW'(N - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
            Y_LAST     <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else if (load) begin
            if (any_gnt) begin
                Y_VALID <= 1'b1;
                Y_DATA  <= I_DATA[gnt_idx*W +: W];
                Y_SEL   <= gnt_idx;
                ptr     <= gnt_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
                Y_LAST     <= I_LAST[gnt_idx];
                lock_q     <= !I_LAST[gnt_idx];
                lock_idx_q <= gnt_idx;
`endif
            end else begin
                Y_VALID <= 1'b0;
            end
        end
    end

endmodule
